// File: rtl/median_3x3_filter.sv
// Three-stage pipelined 3x3 median: per-row sort, then max-of-lows / median-of-mids /
// min-of-highs, then median of those three. One window per clock, fixed 3-cycle latency.
module median_3x3_filter #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] i_p0,
  input  logic [PIXEL_WIDTH-1:0] i_p1,
  input  logic [PIXEL_WIDTH-1:0] i_p2,
  input  logic [PIXEL_WIDTH-1:0] i_p3,
  input  logic [PIXEL_WIDTH-1:0] i_p4,
  input  logic [PIXEL_WIDTH-1:0] i_p5,
  input  logic [PIXEL_WIDTH-1:0] i_p6,
  input  logic [PIXEL_WIDTH-1:0] i_p7,
  input  logic [PIXEL_WIDTH-1:0] i_p8,
  output logic [PIXEL_WIDTH-1:0] o_median
);

  localparam int W = PIXEL_WIDTH;
  typedef logic [W-1:0] pix_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a < b) ? b : a;
  endfunction

  // Three compare-exchanges; result packed as {hi, mid, lo}.
  function automatic logic [3*W-1:0] sort3(input pix_t a, input pix_t b, input pix_t c);
    pix_t x0, x1, y1, y2;
    x0 = min2(a, b);
    x1 = max2(a, b);
    y1 = min2(x1, c);
    y2 = max2(x1, c);
    return {y2, max2(x0, y1), min2(x0, y1)};
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  pix_t lo_d  [3];
  pix_t mid_d [3];
  pix_t hi_d  [3];
  pix_t lo_q  [3];
  pix_t mid_q [3];
  pix_t hi_q  [3];
  pix_t a_d, b_d, c_d;
  pix_t a_q, b_q, c_q;
  pix_t med_d, med_q;

  always_comb begin
    {hi_d[0], mid_d[0], lo_d[0]} = sort3(i_p0, i_p1, i_p2);
    {hi_d[1], mid_d[1], lo_d[1]} = sort3(i_p3, i_p4, i_p5);
    {hi_d[2], mid_d[2], lo_d[2]} = sort3(i_p6, i_p7, i_p8);
  end

  always_comb begin
    a_d   = max2(max2(lo_q[0], lo_q[1]), lo_q[2]);
    b_d   = med3(mid_q[0], mid_q[1], mid_q[2]);
    c_d   = min2(min2(hi_q[0], hi_q[1]), hi_q[2]);
    med_d = med3(a_q, b_q, c_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        lo_q[i]  <= '0;
        mid_q[i] <= '0;
        hi_q[i]  <= '0;
      end
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      med_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        lo_q[i]  <= lo_d[i];
        mid_q[i] <= mid_d[i];
        hi_q[i]  <= hi_d[i];
      end
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      med_q <= med_d;
    end
  end

  assign o_median = med_q;

endmodule

// File: tb/tb_median_3x3_filter.sv
// Scoreboard bench for median_3x3_filter: expected medians are queued with the cycle
// their window was driven and compared exactly three edges later.
module tb_median_3x3_filter;

  typedef logic [8:0][7:0] win_t;
  typedef struct {
    logic [7:0] val;
    int         t;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  win_t       win = '0;
  logic [7:0] o_median;

  ent_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  median_3x3_filter #(.PIXEL_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_p0     (win[0]),
    .i_p1     (win[1]),
    .i_p2     (win[2]),
    .i_p3     (win[3]),
    .i_p4     (win[4]),
    .i_p5     (win[5]),
    .i_p6     (win[6]),
    .i_p7     (win[7]),
    .i_p8     (win[8]),
    .o_median (o_median)
  );

  always #5 clk = ~clk;

  // Reference: full sort of the nine values, pick the 5th smallest.
  function automatic logic [7:0] med9(input win_t w);
    logic [7:0] a [9];
    logic [7:0] tmp;
    for (int i = 0; i < 9; i++) a[i] = w[i];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
        end
    return a[4];
  endfunction

  function automatic win_t rand_win();
    win_t w;
    bit   narrow;
    narrow = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 9; i++)
      w[i] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom);
    return w;
  endfunction

  task automatic drive(input win_t w, input bit push, input logic [7:0] exp_val);
    @(negedge clk);
    win = w;
    if (push) sb.push_back('{val: exp_val, t: cyc});
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(rand_win(), 1'b0, 8'h00);
      advance();
      checks++;
      if (o_median !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %0h expected 00", k, o_median);
      end
    end
    sb.delete();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive('0, 1'b0, 8'h00);
      advance();
      checks++;
      if (o_median !== 8'h00) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %0h expected 00", k, o_median);
      end
    end
  endtask

  task automatic test_directed();
    win_t       w;
    win_t       wins[$];
    logic [7:0] exps[$];
    ent_t       e;
    int         perm [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    int         row  [3] = '{10, 20, 30};

    for (int i = 0; i < 9; i++) w[i] = 8'(i + 1);
    wins.push_back(w); exps.push_back(8'd5);
    for (int i = 0; i < 9; i++) w[i] = 8'(perm[i]);
    wins.push_back(w); exps.push_back(8'd5);
    for (int i = 0; i < 9; i++) w[i] = 8'(9 - i);
    wins.push_back(w); exps.push_back(8'd5);
    for (int i = 0; i < 9; i++) w[i] = 8'hAB;
    wins.push_back(w); exps.push_back(8'hAB);
    for (int i = 0; i < 9; i++) w[i] = 8'(row[i % 3]);
    wins.push_back(w); exps.push_back(8'd20);
    for (int i = 0; i < 9; i++) w[i] = 8'hFF;
    wins.push_back(w); exps.push_back(8'hFF);
    for (int i = 0; i < 9; i++) w[i] = (i == 4) ? 8'hFF : 8'h40;
    wins.push_back(w); exps.push_back(8'h40);
    for (int i = 0; i < 9; i++) w[i] = (i == 0 || i == 2 || i == 6 || i == 8) ? 8'hFF : 8'h00;
    wins.push_back(w); exps.push_back(8'h00);
    for (int i = 0; i < 9; i++) w[i] = (i >= 1 && i <= 4) ? 8'hFF : 8'h00;
    wins.push_back(w); exps.push_back(8'h00);
    for (int i = 0; i < 9; i++) w[i] = (i < 5) ? 8'hFF : 8'h00;
    wins.push_back(w); exps.push_back(8'hFF);

    for (int k = 0; k < wins.size() + 3; k++) begin
      if (k < wins.size()) drive(wins[k], 1'b1, exps[k]);
      else                 drive(rand_win(), 1'b0, 8'h00);
      advance();
      while (sb.size() > 0 && cyc - sb[0].t >= 3) begin
        e = sb.pop_front();
        checks++;
        if (o_median !== e.val) begin
          errors++;
          $display("FAIL directed: got %0h expected %0h", o_median, e.val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    win_t w;
    ent_t e;
    for (int k = 0; k < 1003; k++) begin
      w = rand_win();
      drive(w, k < 1000, med9(w));
      advance();
      while (sb.size() > 0 && cyc - sb[0].t >= 3) begin
        e = sb.pop_front();
        checks++;
        if (o_median !== e.val) begin
          errors++;
          $display("FAIL stream: got %0h expected %0h", o_median, e.val);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    win_t w;
    ent_t e;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(16, 255));
      drive(w, 1'b1, med9(w));
      advance();
      while (sb.size() > 0 && cyc - sb[0].t >= 3) begin
        e = sb.pop_front();
        checks++;
        if (o_median !== e.val) begin
          errors++;
          $display("FAIL pre_reset: got %0h expected %0h", o_median, e.val);
        end
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(16, 255));
    drive(w, 1'b0, 8'h00);
    advance();
    sb.delete();
    checks++;
    if (o_median !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got %0h expected 00", o_median);
    end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(16, 255));
      drive(w, k < 12, med9(w));
      advance();
      if (k < 2) begin
        checks++;
        if (o_median !== 8'h00) begin
          errors++;
          $display("FAIL reset_flush[%0d]: got %0h expected 00", k, o_median);
        end
      end
      while (sb.size() > 0 && cyc - sb[0].t >= 3) begin
        e = sb.pop_front();
        checks++;
        if (o_median !== e.val) begin
          errors++;
          $display("FAIL post_reset: got %0h expected %0h", o_median, e.val);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
